// File: rtl/wave_fetcher.sv
// -----------------------------------------------------------------------------
// wave_fetcher
//
// Instruction-fetch stage for one SIMD unit. It sits between the per-wave PC
// block and the decoder. On fetch_start it latches the active wave's PC and
// issues one read to program memory. It then holds the returned instruction
// for the decoder until the decoder acknowledges it, and on that acknowledge
// it pulses update_pc so the PC block advances the active wave.
//
// Optional build macro: FETCH_STALL_CNT_EN
//   When this macro is defined, the block adds the stall_cycles output. It is a
//   saturating count of the cycles spent in REQ while memory was not ready.
//   The count is cleared only by rst, not by flush.
//
// Ports
//   clk             in   clock; all state changes on the rising edge
//   rst             in   synchronous, active-high reset
//   fetch_start     in   start a fetch for the active wave (honoured in IDLE)
//   flush           in   abort the current fetch; wins over every other event
//   current_pc      in   PC of the active wave
//   mem_read_valid  out  read request to program memory (state == REQ)
//   mem_read_addr   out  request address, latched at fetch_start
//   mem_read_ready  in   memory accepts; mem_read_data valid in the same cycle
//   mem_read_data   in   instruction word from memory
//   instr_valid     out  instr holds a fetched instruction (state == FETCHED)
//   instr           out  fetched instruction for the decoder
//   instr_ack       in   decoder consumes instr
//   update_pc       out  advance the active wave's PC (combinational)
//   fetcher_state   out  IDLE=0, REQ=1, FETCHED=2
//   stall_cycles    out  (FETCH_STALL_CNT_EN only) REQ cycles with ready low
//   busy            out  state is not IDLE
//
// Handshake: a memory transfer happens on a rising edge where mem_read_valid
// and mem_read_ready are both high. A decoder transfer happens on a rising edge
// where instr_valid and instr_ack are both high. A valid stays high, and its
// address or data stays stable, until the transfer completes or a flush or
// reset occurs. A ready or ack seen while the matching valid is low is ignored.
// -----------------------------------------------------------------------------
module wave_fetcher #(
   parameter int PROGRAM_MEM_ADDR_WIDTH = 32,
   parameter int INSTR_WIDTH            = 16
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              fetch_start,
   input  logic                              flush,
   input  logic [PROGRAM_MEM_ADDR_WIDTH-1:0] current_pc,
   output logic                              mem_read_valid,
   output logic [PROGRAM_MEM_ADDR_WIDTH-1:0] mem_read_addr,
   input  logic                              mem_read_ready,
   input  logic [INSTR_WIDTH-1:0]            mem_read_data,
   output logic                              instr_valid,
   output logic [INSTR_WIDTH-1:0]            instr,
   input  logic                              instr_ack,
   output logic                              update_pc,
   output logic [1:0]                        fetcher_state,
`ifdef FETCH_STALL_CNT_EN
   output logic [31:0]                       stall_cycles,
`endif
   output logic                              busy
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      FETCHED = 2'd2
   } state_e;

   state_e                              state_q;
   logic [PROGRAM_MEM_ADDR_WIDTH-1:0]   addr_q;
   logic [INSTR_WIDTH-1:0]              instr_q;

   // Flush is checked before the per-state transitions. This lets it override
   // a same-cycle fetch_start, mem_read_ready or instr_ack.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         instr_q <= '0;
      end else if (flush) begin
         state_q <= IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (fetch_start) begin
                  state_q <= REQ;
                  addr_q  <= current_pc;
               end
            end
            REQ: begin
               if (mem_read_ready) begin
                  state_q <= FETCHED;
                  instr_q <= mem_read_data;
               end
            end
            FETCHED: begin
               if (instr_ack) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign mem_read_valid = (state_q == REQ);
   assign mem_read_addr  = addr_q;
   assign instr_valid    = (state_q == FETCHED);
   assign instr          = instr_q;
   assign fetcher_state  = state_q;
   assign busy           = (state_q != IDLE);

   // update_pc fires on the same edge that retires FETCHED. Because of that,
   // the PC block has already advanced current_pc by the first IDLE cycle.
   assign update_pc = (state_q == FETCHED) & instr_ack & ~flush;

`ifdef FETCH_STALL_CNT_EN
   logic [31:0] stall_q;
   logic [31:0] stall_d;

   always_comb begin
      stall_d = stall_q;
      if ((state_q == REQ) && !mem_read_ready && (stall_q != 32'hFFFF_FFFF)) begin
         stall_d = stall_q + 32'd1;
      end
   end

   // Only rst clears the counter, so it keeps counting across flushes.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q <= '0;
      end else begin
         stall_q <= stall_d;
      end
   end

   assign stall_cycles = stall_q;
`endif

endmodule

// File: doc/wave_fetcher.md
Name: wave_fetcher

Overview:
- Instruction-fetch stage for one SIMD unit. It sits between the per-wave PC block and the decoder.
- On a fetch request, it latches the active wave's current PC and reads one instruction word from program memory over a valid/ready handshake.
- It holds the instruction for the decoder until the decoder acknowledges it, then pulses update_pc so the PC block advances the active wave.

Parameters:
- PROGRAM_MEM_ADDR_WIDTH, 32, width of the PC and program-memory address.
- INSTR_WIDTH, 16, width of one instruction word.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- fetch_start  input  1  scheduler asks to fetch for the active wave; honoured only in IDLE.
- flush  input  1  abort the current fetch (new wave dispatched or context switch).
- current_pc  input  PROGRAM_MEM_ADDR_WIDTH  PC of the active wave, from the PC block.
- mem_read_valid  output  1  read request to program memory.
- mem_read_addr  output  PROGRAM_MEM_ADDR_WIDTH  address of the read request.
- mem_read_ready  input  1  memory accepts the request; mem_read_data is valid in this same cycle.
- mem_read_data  input  INSTR_WIDTH  instruction word returned by memory.
- instr_valid  output  1  instr holds a fetched instruction.
- instr  output  INSTR_WIDTH  fetched instruction, sent to the decoder.
- instr_ack  input  1  decoder consumes instr.
- update_pc  output  1  advance the active wave's PC; goes to the PC block.
- fetcher_state  output  2  IDLE=0, REQ=1, FETCHED=2; 3 is unused.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- State register transitions:
  - IDLE -> REQ on fetch_start. At that edge, latch current_pc into addr_q.
  - REQ -> FETCHED on the edge where mem_read_ready=1. At that edge, capture mem_read_data into instr_q.
  - FETCHED -> IDLE on the edge where instr_ack=1.
  - Any state -> IDLE on flush.
- Request outputs:
  - mem_read_valid = (state==REQ).
  - mem_read_addr = addr_q, held stable for the whole of REQ. Changes on current_pc during REQ have no effect.
- Decoder outputs:
  - instr_valid = (state==FETCHED).
  - instr = instr_q, held stable throughout FETCHED.
- PC update:
  - update_pc = (state==FETCHED) & instr_ack & ~flush, combinational.
  - The PC block increments on that same edge, so current_pc is already advanced in the first IDLE cycle.
  - update_pc is high at most one cycle per fetched instruction.
- Latency:
  - fetch_start to mem_read_valid: 1 cycle.
  - mem_read_ready to instr_valid: 1 cycle.
  - Minimum fetch_start-to-instr_valid: 2 cycles with a zero-wait memory.
  - Back-to-back: fetch_start may be asserted in the first IDLE cycle after ack, and it samples the incremented PC.
- Ignored inputs:
  - fetch_start outside IDLE is ignored, with no queuing.
  - instr_ack outside FETCHED is ignored.
  - mem_read_ready outside REQ is ignored.
- Flush priority: flush wins over every simultaneous event.
  - flush with instr_ack: no update_pc, go to IDLE.
  - flush with mem_read_ready: data discarded, go to IDLE.
  - flush with fetch_start in IDLE: stay in IDLE.
- Reset values: state=IDLE, addr_q=0, instr_q=0. Therefore mem_read_valid=0, mem_read_addr=0, instr_valid=0, instr=0, update_pc=0, busy=0, fetcher_state=0.
- Reset during REQ drops the request: mem_read_valid is 0 in the cycle after the reset edge.
- Width rules: no arithmetic on the PC in this block. The address is passed through at full PROGRAM_MEM_ADDR_WIDTH.

Optional Feature:
- Macro: FETCH_STALL_CNT_EN.
- With the macro defined:
  - Adds output stall_cycles, 32 bits.
  - Increments on every cycle with state==REQ and mem_read_ready=0.
  - Saturates at 32'hFFFFFFFF.
  - Cleared only by rst, not by flush.
- Without the macro: the port and counter are absent, and all other behaviour is identical.

Test Plan:
- Zero-wait fetch, not an end-to-end PC-block test:
  - Stimulus: PC=0, fetch_start, memory ready immediately with data 16'hA5C3, instr_ack held high.
  - Expect: mem_read_valid high in cycle 1 with addr 0; instr_valid with 16'hA5C3 in cycle 2; update_pc high for exactly 1 cycle; IDLE in cycle 3.
- Wait states:
  - Stimulus: current_pc=7, ready withheld 3 cycles; current_pc driven to 9 during REQ.
  - Expect: mem_read_addr stays 7 throughout; instr_valid appears 1 cycle after ready. With the macro, stall_cycles=3.
- Decoder backpressure:
  - Stimulus: instr_ack low for 4 cycles in FETCHED; fetch_start pulsed during that time.
  - Expect: instr stable, update_pc stays 0, fetch_start ignored; a single update_pc when ack rises.
- Flush collisions:
  - Stimulus: flush together with mem_read_ready; separately, flush together with instr_ack.
  - Expect: IDLE next cycle, instr_valid=0, update_pc never asserted.
- Reset mid-REQ:
  - Stimulus: rst=1 while mem_read_valid=1.
  - Expect: all outputs at reset values the next cycle; stall_cycles=0 if enabled.
- Back-to-back fetches:
  - Stimulus: fetch at PC 4 (current_pc driven to 5 after the update_pc pulse), then fetch_start in the first IDLE cycle.
  - Expect: second request addr=5, two update_pc pulses total.
